audio_peak_sched: RTL and testbench

//  Two-channel (L/R) audio peak meter. One shared |x| -> uint15_log2 datapath (int_redAbs then uint15_log2), time-shared between channels by a round-robin arbiter.

---
 rtl/audio_peak_sched.sv | 189 ++++++++++++++++++
 tb/tb_audio_peak_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_peak_sched.sv
// ============================================================================
//  Module   : audio_peak_sched
//  Purpose  : Two-channel (L/R) audio peak meter. A single |x| -> log2
//             datapath is shared by both channels through a round-robin
//             arbiter. Each channel keeps a 4-bit peak level that is held
//             for HOLD_TICKS decay ticks and then decays linearly.
//  Ports    : clk, rst_n (async, active low)
//             smp_l/smp_l_vld, smp_r/smp_r_vld : sample inputs and strobes
//             clip_clr                         : clears the sticky clip flags
//             lvl_l/lvl_r                      : peak levels 0..15
//             drop_l/drop_r                    : pending sample overwritten
//             clip_l/clip_r                    : sticky clip flags
//  Config   : define PEAK_CLIP_EN to enable the clip flags; when it is not
//             defined clip_l/clip_r are tied low and clip_clr is ignored.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_peak_sched #(
    parameter int WS         = 16,     // datapath fixed at 16 bits
    parameter int DECAY_CYC  = 48000,  // clk cycles per decay tick, >= 2
    parameter int HOLD_TICKS = 8       // ticks a fresh peak is held, 1..255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [WS-1:0] smp_l,
    input  logic          smp_l_vld,
    input  logic [WS-1:0] smp_r,
    input  logic          smp_r_vld,
    input  logic          clip_clr,
    output logic [3:0]    lvl_l,
    output logic [3:0]    lvl_r,
    output logic          drop_l,
    output logic          drop_r,
    output logic          clip_l,
    output logic          clip_r
);

    localparam int CW = $clog2(DECAY_CYC);

    typedef enum logic {CH_L = 1'b0, CH_R = 1'b1} ch_e;

    // Index 0 = left, index 1 = right throughout.
    logic [1:0]           vld;
    logic [1:0]           pend_q, pend_d;
    logic [1:0][WS-1:0]   buf_q;
    logic [1:0]           drop_q, drop_d;
    ch_e                  rr_q, rr_d;
    logic [1:0]           gnt;

    logic                 s1_vld_q;
    ch_e                  s1_ch_q;
    logic [WS-2:0]        s1_a_q;
    logic [WS-2:0]        a1_d;
    logic [WS-1:0]        sel;

    logic [3:0]           lv;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 tick;
    logic [1:0][3:0]      peak_q, peak_d;
    logic [1:0][7:0]      hold_q, hold_d;

    assign vld = {smp_r_vld, smp_l_vld};

    // Round-robin arbiter: with both pending the pointer channel wins;
    // the pointer always ends up on the channel that was not granted.
    always_comb begin
        gnt  = 2'b00;
        rr_d = rr_q;
        case (pend_q)
            2'b11: begin
                gnt  = (rr_q == CH_L) ? 2'b01 : 2'b10;
                rr_d = (rr_q == CH_L) ? CH_R : CH_L;
            end
            2'b01: begin
                gnt  = 2'b01;
                rr_d = CH_R;
            end
            2'b10: begin
                gnt  = 2'b10;
                rr_d = CH_L;
            end
            default: ;
        endcase
    end

    // A strobe arriving while the channel is granted re-arms pend without a
    // drop, since the buffered sample is leaving this very cycle.
    assign pend_d = vld | (pend_q & ~gnt);
    assign drop_d = vld & pend_q & ~gnt;

    // Stage 1: one's-complement magnitude of the granted buffer.
    assign sel  = gnt[1] ? buf_q[1] : buf_q[0];
    assign a1_d = sel[WS-1] ? ~sel[WS-2:0] : sel[WS-2:0];

    // Stage 2: highest set bit position + 1, zero for a zero magnitude.
    always_comb begin
        lv = 4'd0;
        for (int b = 0; b < WS-1; b++) begin
            if (s1_a_q[b]) lv = 4'(b + 1);
        end
    end

    // Decay tick generator.
    assign tick  = (cnt_q == CW'(DECAY_CYC - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // Peak/hold update; a qualifying stage-2 result takes priority over decay.
    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        for (int c = 0; c < 2; c++) begin
            if (s1_vld_q && (s1_ch_q == ch_e'(c)) && (lv >= peak_q[c])) begin
                peak_d[c] = lv;
                hold_d[c] = 8'(HOLD_TICKS);
            end else if (tick) begin
                if (hold_q[c] != 8'd0) begin
                    hold_d[c] = hold_q[c] - 8'd1;
                end else if (peak_q[c] != 4'd0) begin
                    peak_d[c] = peak_q[c] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            buf_q    <= '0;
            drop_q   <= '0;
            rr_q     <= CH_L;
            s1_vld_q <= 1'b0;
            s1_ch_q  <= CH_L;
            s1_a_q   <= '0;
            cnt_q    <= '0;
            peak_q   <= '0;
            hold_q   <= '0;
        end else begin
            pend_q   <= pend_d;
            drop_q   <= drop_d;
            rr_q     <= rr_d;
            if (smp_l_vld) buf_q[0] <= smp_l;
            if (smp_r_vld) buf_q[1] <= smp_r;
            s1_vld_q <= |gnt;
            s1_ch_q  <= gnt[1] ? CH_R : CH_L;
            s1_a_q   <= a1_d;
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            hold_q   <= hold_d;
        end
    end

    assign lvl_l  = peak_q[0];
    assign lvl_r  = peak_q[1];
    assign drop_l = drop_q[0];
    assign drop_r = drop_q[1];

`ifdef PEAK_CLIP_EN
    logic [1:0] clip_q, clip_d, clip_set;

    // A full-scale magnitude marks the channel; a set beats a same-cycle clear.
    always_comb begin
        clip_set = 2'b00;
        if (s1_vld_q && (s1_a_q == {(WS-1){1'b1}})) begin
            clip_set[s1_ch_q] = 1'b1;
        end
        clip_d = clip_set | (clip_q & {2{~clip_clr}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_q <= '0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clip_l = clip_q[0];
    assign clip_r = clip_q[1];
`else
    logic unused_clip_clr;
    assign unused_clip_clr = clip_clr;
    assign clip_l = 1'b0;
    assign clip_r = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_peak_sched.sv
`default_nettype none

module tb_audio_peak_sched;

    localparam int DECAY = 6;
    localparam int HOLD  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] smp_l, smp_r;
    logic        smp_l_vld, smp_r_vld, clip_clr;
    logic [3:0]  lvl_l, lvl_r;
    logic        drop_l, drop_r, clip_l, clip_r;

    int vectors = 0;
    int misses  = 0;

    audio_peak_sched #(.WS(16), .DECAY_CYC(DECAY), .HOLD_TICKS(HOLD)) dut (
        .clk(clk), .rst_n(rst_n),
        .smp_l(smp_l), .smp_l_vld(smp_l_vld),
        .smp_r(smp_r), .smp_r_vld(smp_r_vld),
        .clip_clr(clip_clr),
        .lvl_l(lvl_l), .lvl_r(lvl_r),
        .drop_l(drop_l), .drop_r(drop_r),
        .clip_l(clip_l), .clip_r(clip_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misses++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Samples wait in a one-deep per-channel mailbox; each cycle at most one
    // leaves for the log stage; its level lands one cycle later.
    bit          m_pend [2];
    int          m_smp  [2];
    bit          m_ptr_r;          // 1 = right channel has priority on a tie
    bit          m_inflight;
    int          m_in_ch, m_in_mag;
    int          m_peak [2], m_hold [2];
    bit          m_drop [2], m_clip [2];
    longint      m_cyc;

    function automatic int level_of(input int mag);
        return (mag == 0) ? 0 : $clog2(mag + 1);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_pend[c] = 0; m_smp[c] = 0; m_peak[c] = 0; m_hold[c] = 0;
            m_drop[c] = 0; m_clip[c] = 0;
        end
        m_ptr_r = 0; m_inflight = 0; m_in_ch = 0; m_in_mag = 0; m_cyc = 0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        bit vin [2];
        int sin [2];
        bit tk;
        int g;
        vin[0] = smp_l_vld; vin[1] = smp_r_vld;
        sin[0] = int'($signed(smp_l)); sin[1] = int'($signed(smp_r));
        if (!rst_n) begin
            model_reset();
        end else begin
            tk = ((m_cyc % DECAY) == DECAY - 1);
            m_cyc++;
            for (int c = 0; c < 2; c++) begin
                int lv;
                bit here;
                here = m_inflight && (m_in_ch == c);
                lv = level_of(m_in_mag);
                if (here && lv >= m_peak[c]) begin
                    m_peak[c] = lv; m_hold[c] = HOLD;
                end else if (tk) begin
                    if (m_hold[c] > 0) m_hold[c]--;
                    else if (m_peak[c] > 0) m_peak[c]--;
                end
`ifdef PEAK_CLIP_EN
                m_clip[c] = (here && m_in_mag == 32767) || (m_clip[c] && !clip_clr);
`else
                m_clip[c] = 0;
`endif
            end
            if (m_pend[0] && m_pend[1]) g = m_ptr_r ? 1 : 0;
            else if (m_pend[0])         g = 0;
            else if (m_pend[1])         g = 1;
            else                        g = -1;
            if (g >= 0) m_ptr_r = (g == 0);
            m_inflight = (g >= 0);
            if (g >= 0) begin
                m_in_ch  = g;
                m_in_mag = (m_smp[g] < 0) ? -m_smp[g] - 1 : m_smp[g];
            end
            for (int c = 0; c < 2; c++) begin
                m_drop[c] = vin[c] && m_pend[c] && (g != c);
                m_pend[c] = vin[c] || (m_pend[c] && (g != c));
                if (vin[c]) m_smp[c] = sin[c];
            end
        end
        #1;
        chk("lvl_l",  int'(lvl_l),  m_peak[0]);
        chk("lvl_r",  int'(lvl_r),  m_peak[1]);
        chk("drop_l", int'(drop_l), int'(m_drop[0]));
        chk("drop_r", int'(drop_r), int'(m_drop[1]));
        chk("clip_l", int'(clip_l), int'(m_clip[0]));
        chk("clip_r", int'(clip_r), int'(m_clip[1]));
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        smp_l_vld = 1'b0; smp_r_vld = 1'b0; clip_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Strobe the selected channels for one cycle; returns on the negedge
    // following the capture edge.
    task automatic pulse(input bit l, input bit r, input logic [15:0] sl, input logic [15:0] sr);
        @(negedge clk);
        smp_l = sl; smp_r = sr; smp_l_vld = l; smp_r_vld = r;
        @(negedge clk);
        smp_l_vld = 1'b0; smp_r_vld = 1'b0;
    endtask

    function automatic logic [15:0] rand_smp();
        logic [15:0] v;
        case ($urandom % 8)
            0: v = 16'h7FFF;
            1: v = 16'h8000;
            2: v = 16'h0000;
            3: v = 16'hFFFF;
            default: v = 16'($urandom >> ($urandom % 32));
        endcase
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        smp_l = '0; smp_r = '0; smp_l_vld = 1'b0; smp_r_vld = 1'b0; clip_clr = 1'b0;
        #12;
        chk("reset_lvl_l", int'(lvl_l), 0);
        chk("reset_drop_l", int'(drop_l), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single left sample 0x0100 -> level 9 two edges after capture.
        pulse(1, 0, 16'h0100, 16'h0000);
        @(posedge clk); #1;
        chk("t1_lvl_l_k1", int'(lvl_l), 0);
        @(posedge clk); #1;
        chk("t1_lvl_l_k2", int'(lvl_l), 9);
        chk("t1_lvl_r", int'(lvl_r), 0);
        chk("t1_drop_l", int'(drop_l), 0);

        // -1 has zero magnitude; 0x8000 is full scale.
        do_reset();
        pulse(1, 0, 16'hFFFF, 16'h0000);
        repeat (3) @(posedge clk); #1;
        chk("t2_neg1", int'(lvl_l), 0);
        pulse(1, 0, 16'h8000, 16'h0000);
        repeat (2) @(posedge clk); #1;
        chk("t2_8000", int'(lvl_l), 15);
`ifdef PEAK_CLIP_EN
        chk("t2_clip_l", int'(clip_l), 1);
`else
        chk("t2_clip_l", int'(clip_l), 0);
`endif

        // Simultaneous strobes: left first, right one cycle later.
        do_reset();
        pulse(1, 1, 16'h0010, 16'h4000);
        @(posedge clk); #1;
        chk("t3_l_k1", int'(lvl_l), 0);
        @(posedge clk); #1;
        chk("t3_l_k2", int'(lvl_l), 5);
        chk("t3_r_k2", int'(lvl_r), 0);
        @(posedge clk); #1;
        chk("t3_r_k3", int'(lvl_r), 15);

        // Asynchronous reset clears outputs without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_lvl_l", int'(lvl_l), 0);
        chk("async_lvl_r", int'(lvl_r), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n     = ($urandom % 500) != 0;
            smp_l     = rand_smp();
            smp_r     = rand_smp();
            smp_l_vld = ($urandom % 100) < ((i / 1000) * 20 + 10);
            smp_r_vld = ($urandom % 100) < ((i / 1000) * 20 + 10);
            clip_clr  = ($urandom % 20) == 0;
        end
        @(negedge clk);
        rst_n = 1'b1; smp_l_vld = 1'b0; smp_r_vld = 1'b0; clip_clr = 1'b0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

`default_nettype wire
